// File: rtl/imem_loader.sv
// Byte-stream boot loader: assembles little-endian bytes into instruction words and
// writes them to sequential instruction-memory addresses starting at 0.
module imem_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    output logic                         rx_ready,
    output logic [$clog2(MEM_DEPTH)-1:0] waddr,
    output logic [DATA_WIDTH-1:0]        wdata,
    output logic                         wen,
    output logic                         busy,
    output logic                         done,
    output logic                         error
);

    localparam int AW  = $clog2(MEM_DEPTH);
    localparam int BPW = DATA_WIDTH / 8;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
    // Wide enough that a frame of exactly MEM_DEPTH words compares correctly.
    localparam int WCW = (AW + 1 > 16) ? AW + 1 : 16;

    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE} state_t;

    state_t                  state_reg, state_next;
    logic [15:0]             len_reg, len_next;
    logic [WCW-1:0]          word_cnt_reg, word_cnt_next;
    logic [BCW-1:0]          byte_cnt_reg, byte_cnt_next;
    logic [AW-1:0]           waddr_reg, waddr_next;
    logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
    logic                    error_reg, error_next;

    logic                    transfer;
    logic [BPW-1:0]          lane_sel;
    logic [15:0]             full_len;
    logic                    last_byte;
    logic                    last_word;

    generate
        for (genvar gi = 0; gi < BPW; gi++) begin : g_lane
            assign lane_sel[gi] = (byte_cnt_reg == BCW'(gi));
        end
    endgenerate

    assign rx_ready  = (state_reg == LEN_LO) || (state_reg == LEN_HI) || (state_reg == DATA);
    assign wen       = (state_reg == WRITE);
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);
    assign waddr     = waddr_reg;
    assign wdata     = wdata_reg;
    assign error     = error_reg;

    assign transfer  = rx_valid && rx_ready;
    assign full_len  = {rx_data, len_reg[7:0]};
    assign last_byte = (byte_cnt_reg == BCW'(BPW - 1));
    assign last_word = (word_cnt_reg == (WCW'(len_reg) - WCW'(1)));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= IDLE;
            len_reg      <= '0;
            word_cnt_reg <= '0;
            byte_cnt_reg <= '0;
            waddr_reg    <= '0;
            wdata_reg    <= '0;
            error_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            len_reg      <= len_next;
            word_cnt_reg <= word_cnt_next;
            byte_cnt_reg <= byte_cnt_next;
            waddr_reg    <= waddr_next;
            wdata_reg    <= wdata_next;
            error_reg    <= error_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        len_next      = len_reg;
        word_cnt_next = word_cnt_reg;
        byte_cnt_next = byte_cnt_reg;
        waddr_next    = waddr_reg;
        wdata_next    = wdata_reg;
        error_next    = error_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next    = LEN_LO;
                    error_next    = 1'b0;
                    waddr_next    = '0;
                    word_cnt_next = '0;
                    byte_cnt_next = '0;
                end
            end
            LEN_LO: begin
                if (transfer) begin
                    len_next   = {len_reg[15:8], rx_data};
                    state_next = LEN_HI;
                end
            end
            LEN_HI: begin
                if (transfer) begin
                    len_next = full_len;
                    if (full_len == 16'd0) begin
                        state_next = DONE;
                    end else if ({16'd0, full_len} > 32'(MEM_DEPTH)) begin
                        error_next = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (transfer) begin
                    for (int i = 0; i < BPW; i++) begin
                        if (lane_sel[i]) begin
                            wdata_next[8*i +: 8] = rx_data;
                        end
                    end
                    if (last_byte) begin
                        byte_cnt_next = '0;
                        state_next    = WRITE;
                    end else begin
                        byte_cnt_next = byte_cnt_reg + BCW'(1);
                    end
                end
            end
            WRITE: begin
                // Address advances only after the strobe cycle so waddr/wdata are stable with wen.
                if (last_word) begin
                    state_next = DONE;
                end else begin
                    waddr_next    = waddr_reg + AW'(1);
                    word_cnt_next = word_cnt_reg + WCW'(1);
                    state_next    = DATA;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames are streamed byte by byte and every
// observed memory write is compared against hand-computed words and addresses.
module tb_imem_loader;

    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          wen;
    logic          busy;
    logic          done;
    logic          error;

    imem_loader #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .waddr    (waddr),
        .wdata    (wdata),
        .wen      (wen),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    int cycle = 0;
    int done_cnt = 0;
    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];
    int            wc_q[$];

    always @(posedge clock) cycle <= cycle + 1;

    // Write/done monitor, sampled mid-cycle.
    always @(negedge clock) begin
        if (wen === 1'b1) begin
            wa_q.push_back(waddr);
            wd_q.push_back(wdata);
            wc_q.push_back(cycle);
        end
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
    endtask

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic send_byte(input logic [7:0] b);
        logic ok;
        ok = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (rx_ready === 1'b1) begin
                ok = 1'b1;
                @(negedge clock);
                break;
            end
            @(negedge clock);
        end
        if (!ok) check("byte_accepted", {63'd0, ok}, 64'd1);
    endtask

    task automatic send_gap_byte(input logic [7:0] b);
        if ($urandom_range(0, 2) == 0) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clock);
        end
        send_byte(b);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check(tag, {63'd0, ok}, 64'd1);
    endtask

    function automatic logic [31:0] img_word(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h0F1E2D3C;
    endfunction

    initial begin
        int t0;
        int base;
        int n;
        logic [31:0] w;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_rx_ready", {63'd0, rx_ready}, 64'd0);
        check("rst_wen",      {63'd0, wen},      64'd0);
        check("rst_busy",     {63'd0, busy},     64'd0);
        check("rst_done",     {63'd0, done},     64'd0);
        check("rst_error",    {63'd0, error},    64'd0);
        check("rst_waddr",    64'(waddr),        64'd0);
        check("rst_wdata",    64'(wdata),        64'd0);
        reset = 1'b0;
        @(negedge clock);

        // Two-word frame, continuous stream
        clear_log();
        base  = done_cnt;
        t0    = cycle;
        pulse_start();
        check("f1_busy_lenlo",  {63'd0, busy},     64'd1);
        check("f1_ready_lenlo", {63'd0, rx_ready}, 64'd1);
        send_byte(8'h02);
        send_byte(8'h00);
        send_word(32'h0000_0013);
        send_word(32'h0010_0093);
        rx_valid = 1'b0;
        wait_done("f1_done_seen", 10);
        @(negedge clock);
        check("f1_done_one_cycle", {63'd0, done}, 64'd0);
        check("f1_busy_after",     {63'd0, busy}, 64'd0);
        check("f1_nwrites", 64'(wa_q.size()), 64'd2);
        if (wa_q.size() == 2) begin
            check("f1_addr0", 64'(wa_q[0]), 64'd0);
            check("f1_data0", 64'(wd_q[0]), 64'h0000_0013);
            check("f1_addr1", 64'(wa_q[1]), 64'd1);
            check("f1_data1", 64'(wd_q[1]), 64'h0010_0093);
            check("f1_first_wen_latency", 64'(wc_q[0] - t0), 64'd7);
            check("f1_word_spacing",      64'(wc_q[1] - wc_q[0]), 64'd5);
        end
        check("f1_done_pulses", 64'(done_cnt - base), 64'd1);

        // Zero-length frame
        clear_log();
        base = done_cnt;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        rx_valid = 1'b0;
        check("f2_done_next", {63'd0, done},  64'd1);
        check("f2_error",     {63'd0, error}, 64'd0);
        @(negedge clock);
        check("f2_done_clear", {63'd0, done}, 64'd0);
        check("f2_busy_after", {63'd0, busy}, 64'd0);
        check("f2_nwrites",    64'(wa_q.size()), 64'd0);
        check("f2_done_pulses", 64'(done_cnt - base), 64'd1);

        // Oversized frame (1025 words)
        clear_log();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h04);
        rx_valid = 1'b0;
        check("f3_done",  {63'd0, done},  64'd1);
        check("f3_error", {63'd0, error}, 64'd1);
        @(negedge clock);
        check("f3_error_sticky", {63'd0, error}, 64'd1);
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        check("f3_idle_not_ready", {63'd0, rx_ready}, 64'd0);
        @(negedge clock);
        rx_valid = 1'b0;
        check("f3_nwrites", 64'(wa_q.size()), 64'd0);

        // Next start clears error; reset mid-frame during word 3
        clear_log();
        base = done_cnt;
        pulse_start();
        check("f4_error_cleared", {63'd0, error}, 64'd0);
        send_byte(8'h04);
        send_byte(8'h00);
        send_word(32'h1111_1111);
        send_word(32'h2222_2222);
        send_word(32'h3333_3333);
        send_byte(8'h44);
        send_byte(8'h45);
        rx_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        check("f4_rst_rx_ready", {63'd0, rx_ready}, 64'd0);
        check("f4_rst_wen",      {63'd0, wen},      64'd0);
        check("f4_rst_busy",     {63'd0, busy},     64'd0);
        check("f4_rst_done",     {63'd0, done},     64'd0);
        check("f4_rst_waddr",    64'(waddr),        64'd0);
        check("f4_rst_wdata",    64'(wdata),        64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("f4_nwrites", 64'(wa_q.size()), 64'd3);
        if (wa_q.size() == 3) begin
            check("f4_addr2", 64'(wa_q[2]), 64'd2);
            check("f4_data2", 64'(wd_q[2]), 64'h3333_3333);
        end
        check("f4_no_done", 64'(done_cnt - base), 64'd0);

        clear_log();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_word(32'hDEAD_BEEF);
        rx_valid = 1'b0;
        wait_done("f5_done_seen", 10);
        @(negedge clock);
        check("f5_nwrites", 64'(wa_q.size()), 64'd1);
        if (wa_q.size() == 1) begin
            check("f5_addr0", 64'(wa_q[0]), 64'd0);
            check("f5_data0", 64'(wd_q[0]), 64'hDEAD_BEEF);
        end

        // start held during DATA/WRITE; byte offered during WRITE is held off
        clear_log();
        base = done_cnt;
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'hA1);
        send_byte(8'hA2);
        send_byte(8'hA3);
        start = 1'b1;
        send_byte(8'hA4);
        rx_data  = 8'hB1;
        rx_valid = 1'b1;
        check("f6_write_wen",      {63'd0, wen},      64'd1);
        check("f6_write_not_ready", {63'd0, rx_ready}, 64'd0);
        check("f6_write_waddr",    64'(waddr),        64'd0);
        check("f6_write_wdata",    64'(wdata),        64'hA4A3_A2A1);
        send_byte(8'hB1);
        start = 1'b0;
        send_byte(8'hB2);
        send_byte(8'hB3);
        send_byte(8'hB4);
        rx_valid = 1'b0;
        wait_done("f6_done_seen", 10);
        @(negedge clock);
        check("f6_nwrites", 64'(wa_q.size()), 64'd2);
        if (wa_q.size() == 2) begin
            check("f6_addr1", 64'(wa_q[1]), 64'd1);
            check("f6_data1", 64'(wd_q[1]), 64'hB4B3_B2B1);
        end
        check("f6_done_pulses", 64'(done_cnt - base), 64'd1);

        // Full 1024-word image with random rx_valid gaps
        clear_log();
        pulse_start();
        send_gap_byte(8'h00);
        send_gap_byte(8'h04);
        for (int i = 0; i < DEPTH; i++) begin
            w = img_word(i);
            for (int b = 0; b < 4; b++) send_gap_byte(w[8*b +: 8]);
        end
        rx_valid = 1'b0;
        wait_done("f7_done_seen", 20);
        check("f7_error", {63'd0, error}, 64'd0);
        @(negedge clock);
        check("f7_nwrites", 64'(wa_q.size()), 64'(DEPTH));
        check("f7_last_waddr_held", 64'(waddr), 64'(DEPTH - 1));
        n = (wa_q.size() < DEPTH) ? wa_q.size() : DEPTH;
        for (int i = 0; i < n; i++) begin
            check($sformatf("f7_addr%0d", i), 64'(wa_q[i]), 64'(i));
            check($sformatf("f7_data%0d", i), 64'(wd_q[i]), 64'(img_word(i)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
